// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// Covers the state enum, opcode values, ALU function codes and datapath mux select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_A  = 1'b1;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // States that sit on a memory handshake and are subject to the timeout.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-cycle counter with limit compare.
// hit fires on the wait cycle whose increment would reach LIMIT; LIMIT=0 never fires.
module mc_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    hit = (LIMIT != 0) && inc && (count == CW'(LIMIT - 1));
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit with ready-based memory handshakes, timeout trap,
// illegal-opcode trap and a retired-instruction counter.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW        = 32,
  parameter int HAS_JAL     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            mem_write,
  output logic            ir_write,
  output logic            pc_write,
  output logic            pc_cond,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_source,
  output logic [1:0]      reg_dst,
  output logic [1:0]      mem_to_reg,
  output logic [5:0]      alu_op,
  output logic            illegal,
  output logic            bus_err,
  output logic            retire,
  output logic [CNTW-1:0] instr_count
);

  state_e          state, state_nx;
  logic            illegal_q, bus_err_q;
  logic [CNTW-1:0] count_q;
  logic            set_ill, set_berr;
  logic            waiting, rdy, tmo;

  assign waiting = is_wait_state(state);
  assign rdy     = (state == S_FETCH) ? imem_ready : dmem_ready;

  mc_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait (
    .clk   (clk),
    .reset (reset),
    .clr   (state_nx != state),
    .inc   (waiting && !rdy),
    .hit   (tmo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state <= state_nx;
      if (set_ill)  illegal_q <= 1'b1;
      if (set_berr) bus_err_q <= 1'b1;
      if (retire)   count_q   <= count_q + 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    set_ill    = 1'b0;
    set_berr   = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_cond    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_B;
    pc_source  = PCSRC_ALU;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALUOUT;
    alu_op     = 6'h00;
    retire     = 1'b0;

    case (state)
      S_FETCH: begin
        imem_req  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end else if (tmo) begin
          set_berr = 1'b1;
          state_nx = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:     state_nx = S_EXEC_R;
          OP_LW, OP_SW: state_nx = S_MEM_ADDR;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_J:         state_nx = S_JUMP;
          OP_ADDI:      state_nx = S_EXEC_I;
          OP_JAL: begin
            if (HAS_JAL != 0) begin
              state_nx = S_JAL;
            end else begin
              set_ill  = 1'b1;
              state_nx = S_TRAP;
            end
          end
          default: begin
            set_ill  = 1'b1;
            state_nx = S_TRAP;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        alu_op    = funct;
        state_nx  = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = DST_RD;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        state_nx  = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        state_nx  = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_nx = S_MEM_WB;
        end else if (tmo) begin
          set_berr = 1'b1;
          state_nx = S_TRAP;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
        retire     = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEM_WR: begin
        dmem_req  = 1'b1;
        mem_write = 1'b1;
        if (dmem_ready) begin
          retire   = 1'b1;
          state_nx = S_FETCH;
        end else if (tmo) begin
          set_berr = 1'b1;
          state_nx = S_TRAP;
        end
      end
      S_BRANCH: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        alu_op    = ALU_SUB;
        pc_cond   = 1'b1;
        pc_source = PCSRC_ALUOUT;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        reg_dst    = DST_R31;
        mem_to_reg = WB_PC;
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        retire     = 1'b1;
        state_nx   = S_FETCH;
      end
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_TRAP;
    endcase

    // Reset forces every output low in the same cycle, so an access in flight drops.
    if (reset) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_cond    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      pc_source  = 2'd0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alu_op     = 6'h00;
      retire     = 1'b0;
    end
  end

  assign illegal     = illegal_q & ~reset;
  assign bus_err     = bus_err_q & ~reset;
  assign instr_count = reset ? '0 : count_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: each instruction is expanded into its expected
// per-cycle control trace from the instruction-class rules, then replayed against the DUT.
module tb_mc_ctrl_fsm;

  localparam int TMO = 16;
  localparam int CW  = 4;

  localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         JMP = 6'b000010, JAL = 6'b000011, ADDI = 6'b001000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;

  logic imem_req, dmem_req, mem_write, ir_write, pc_write, pc_cond, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source, reg_dst, mem_to_reg;
  logic [5:0] alu_op;
  logic illegal, bus_err, retire;
  logic [CW-1:0] instr_count;

  logic nj_imem_req, nj_dmem_req, nj_mem_write, nj_ir_write, nj_pc_write, nj_pc_cond;
  logic nj_reg_write, nj_alu_src_a, nj_illegal, nj_bus_err, nj_retire;
  logic [1:0] nj_alu_src_b, nj_pc_source, nj_reg_dst, nj_mem_to_reg;
  logic [5:0] nj_alu_op;
  logic [CW-1:0] nj_instr_count;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNTW(CW), .HAS_JAL(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_cond(pc_cond), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .illegal(illegal), .bus_err(bus_err), .retire(retire),
    .instr_count(instr_count)
  );

  mc_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNTW(CW), .HAS_JAL(0)) u_nj (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(nj_imem_req), .dmem_req(nj_dmem_req), .mem_write(nj_mem_write),
    .ir_write(nj_ir_write), .pc_write(nj_pc_write), .pc_cond(nj_pc_cond),
    .reg_write(nj_reg_write), .alu_src_a(nj_alu_src_a), .alu_src_b(nj_alu_src_b),
    .pc_source(nj_pc_source), .reg_dst(nj_reg_dst), .mem_to_reg(nj_mem_to_reg),
    .alu_op(nj_alu_op), .illegal(nj_illegal), .bus_err(nj_bus_err), .retire(nj_retire),
    .instr_count(nj_instr_count)
  );

  typedef struct packed {
    logic imem_req, dmem_req, mem_write, ir_write, pc_write, pc_cond, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source, reg_dst, mem_to_reg;
    logic [5:0] alu_op;
    logic retire;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic imr, dmr, ill, berr;
  } step_t;

  ctl_t obs;
  assign obs = {imem_req, dmem_req, mem_write, ir_write, pc_write, pc_cond, reg_write,
                alu_src_a, alu_src_b, pc_source, reg_dst, mem_to_reg, alu_op, retire};

  step_t q[$];
  int checks = 0, errors = 0;
  int m_count = 0;
  logic m_ill = 1'b0, m_berr = 1'b0, m_trapped = 1'b0;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic push(input ctl_t c, input logic imr, input logic dmr);
    step_t s;
    s.c = c; s.imr = imr; s.dmr = dmr; s.ill = m_ill; s.berr = m_berr;
    q.push_back(s);
  endtask

  task automatic add_trap(input int n);
    for (int i = 0; i < n; i++) push('0, rnd(), rnd());
  endtask

  // Handshake phase: w cycles without ready, then the ready cycle; TMO misses trap instead.
  task automatic add_wait(input ctl_t c, input ctl_t done, input logic is_imem, input int w);
    for (int i = 0; i < w && i < TMO; i++)
      push(c, is_imem ? 1'b0 : rnd(), is_imem ? rnd() : 1'b0);
    if (w >= TMO) begin
      m_berr = 1'b1; m_trapped = 1'b1;
      add_trap(4);
    end else begin
      push(done, is_imem ? 1'b1 : rnd(), is_imem ? rnd() : 1'b1);
    end
  endtask

  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    ctl_t c, d;
    c = '0; c.imem_req = 1'b1; c.alu_src_b = 2'd1; c.alu_op = 6'h20;
    d = c;  d.ir_write = 1'b1; d.pc_write = 1'b1;
    add_wait(c, d, 1'b1, fw);
    if (m_trapped) return;
    c = '0; c.alu_src_b = 2'd3; c.alu_op = 6'h20;
    push(c, rnd(), rnd());
    case (op)
      R_OP, ADDI: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = (op == ADDI) ? 2'd2 : 2'd0;
        c.alu_op = (op == ADDI) ? 6'h20 : fn;
        push(c, rnd(), rnd());
        c = '0; c.reg_write = 1'b1; c.reg_dst = (op == ADDI) ? 2'd0 : 2'd1; c.retire = 1'b1;
        push(c, rnd(), rnd());
      end
      LW, SW: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 6'h20;
        push(c, rnd(), rnd());
        c = '0; c.dmem_req = 1'b1; c.mem_write = (op == SW);
        d = c;  d.retire = (op == SW);
        add_wait(c, d, 1'b0, mw);
        if (!m_trapped && op == LW) begin
          c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'd1; c.retire = 1'b1;
          push(c, rnd(), rnd());
        end
      end
      BEQ: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 6'h22; c.pc_cond = 1'b1; c.pc_source = 2'd1;
        c.retire = 1'b1;
        push(c, rnd(), rnd());
      end
      JMP: begin
        c = '0; c.pc_write = 1'b1; c.pc_source = 2'd2; c.retire = 1'b1;
        push(c, rnd(), rnd());
      end
      JAL: begin
        c = '0; c.reg_write = 1'b1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2; c.pc_write = 1'b1;
        c.pc_source = 2'd2; c.retire = 1'b1;
        push(c, rnd(), rnd());
      end
      default: begin
        m_ill = 1'b1; m_trapped = 1'b1;
        add_trap(6);
      end
    endcase
  endtask

  // Replays up to maxn queued cycles with the given IR fields.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int maxn);
    step_t s;
    int n;
    n = 0;
    while (q.size() > 0 && n < maxn) begin
      s = q.pop_front();
      @(negedge clk);
      opcode = op; funct = fn; imem_ready = s.imr; dmem_ready = s.dmr;
      #1;
      chk("ctl", 64'(obs), 64'(s.c));
      chk("illegal", 64'(illegal), 64'(s.ill));
      chk("bus_err", 64'(bus_err), 64'(s.berr));
      chk("instr_count", 64'(instr_count), 64'(m_count % (1 << CW)));
      if (s.c.retire) m_count++;
      n++;
    end
  endtask

  task automatic exec(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    add_instr(op, fn, fw, mw);
    run(op, fn, 1000);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1; imem_ready = rnd(); dmem_ready = rnd(); opcode = 6'($urandom);
      #1;
      chk("reset_ctl", 64'(obs), 64'(0));
      chk("reset_flags", 64'({illegal, bus_err, nj_illegal}), 64'(0));
      chk("reset_count", 64'(instr_count), 64'(0));
    end
    @(posedge clk);
    #1 reset = 1'b0;
    m_count = 0; m_ill = 1'b0; m_berr = 1'b0; m_trapped = 1'b0;
    q.delete();
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    ops[0] = R_OP; ops[1] = ADDI; ops[2] = LW; ops[3] = SW;
    ops[4] = BEQ;  ops[5] = JMP;  ops[6] = JAL;

    do_reset(3);

    exec(R_OP, 6'h20, 0, 0);
    @(posedge clk); #1;
    chk("add_count", 64'(instr_count), 64'(1));

    exec(LW, 6'h00, 0, 5);

    exec(SW, 6'h00, 0, TMO);
    chk("sw_tmo_bus_err", 64'(bus_err), 64'(1));
    chk("sw_tmo_mem_write", 64'(mem_write), 64'(0));
    do_reset(2);

    exec(SW, 6'h00, 0, TMO - 1);
    exec(LW, 6'h00, 2, TMO - 1);
    exec(SW, 6'h00, 1, 10);
    exec(ADDI, 6'h00, TMO - 1, 0);
    chk("limit_ready_no_trap", 64'(bus_err), 64'(0));

    exec(R_OP, 6'h00, TMO, 0);
    do_reset(2);

    exec(6'h3F, 6'h00, 1, 0);
    chk("illegal_set", 64'(illegal), 64'(1));
    do_reset(2);

    exec(BEQ, 6'h00, 0, 0);
    exec(JMP, 6'h00, 1, 0);
    exec(JAL, 6'h00, 0, 0);
    chk("nojal_illegal", 64'(nj_illegal), 64'(1));
    chk("nojal_idle", 64'({nj_imem_req, nj_pc_write, nj_reg_write}), 64'(0));
    do_reset(1);

    add_instr(LW, 6'h00, 0, 8);
    run(LW, 6'h00, 6);
    chk("midaccess_req", 64'(dmem_req), 64'(1));
    do_reset(1);

    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 6)];
      exec(op, 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
